sifh_threshold_scheduler: RTL and testbench

Shares one window-threshold computation among `N_REQ` histogram-RAM lanes. Each lane presents a peak bin index for one of its pixels. A round-robin arbiter grants one lane per cycle. A two-stage pipeline turns the peak into THminus, THpositive and delta, and stores them in a per-pixel result table. The block sits between the per-RAM peak finders and the TDC window-configuration logic, and signals when every pixel of a frame has a threshold set.

---
 rtl/sifh_pkg.sv | 26 ++
 rtl/sifh_threshold_scheduler_if.sv | 48 ++++
 rtl/sifh_window_calc.sv | 62 ++++++
 rtl/sifh_threshold_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_sifh_threshold_scheduler.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sifh_pkg.sv
// Shared definitions for the SIFH threshold scheduler family.
// Holds the default peak/threshold word widths, the window half-span SB for
// the default peak width, the scheduler FSM state type and helper functions
// for the half-span and the result-table address width.
package sifh_pkg;

  localparam int NB_DEFAULT = 8;
  localparam int NP_DEFAULT = 16;

  // Window half-span: 3/4 of the peak-bin range.
  localparam int SB = (2 ** (NB_DEFAULT - 1)) + (2 ** (NB_DEFAULT - 2));

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } schedState_e;

  function automatic int sifh_sb(input int nb);
    return (2 ** (nb - 1)) + (2 ** (nb - 2));
  endfunction

  function automatic int sifh_table_aw(input int nReq, input int pixPerReq);
    return $clog2(nReq * pixPerReq);
  endfunction

endpackage

// File: rtl/sifh_threshold_scheduler_if.sv
// Bus bundle between the per-RAM peak finders / TDC window configuration and
// the threshold scheduler.
//   frame_start                      : one-cycle frame start pulse
//   req_valid/req_peak_ch/req_pix    : per-lane peak requests
//   req_ready                        : one-hot grant back to the lanes
//   res_valid/res_addr               : table write notification
//   rd_addr                          : table read address
//   rd_thminus/rd_thpositive/rd_delta/rd_written : registered read data
//   frame_done                       : every entry written this frame
// Modport master is the requester/reader side, slave is the scheduler.
interface sifh_threshold_scheduler_if
  import sifh_pkg::*;
#(
  parameter int NB          = NB_DEFAULT,
  parameter int NP          = NP_DEFAULT,
  parameter int N_REQ       = 4,
  parameter int PIX_PER_REQ = 16
);
  localparam int PW = $clog2(PIX_PER_REQ);
  localparam int AW = sifh_table_aw(N_REQ, PIX_PER_REQ);

  logic                           frame_start;
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0][NB-1:0]       req_peak_ch;
  logic [N_REQ-1:0][PW-1:0]       req_pix;
  logic [N_REQ-1:0]               req_ready;
  logic                           res_valid;
  logic [AW-1:0]                  res_addr;
  logic [AW-1:0]                  rd_addr;
  logic [NP-1:0]                  rd_thminus;
  logic [NP-1:0]                  rd_thpositive;
  logic [NP-1:0]                  rd_delta;
  logic                           rd_written;
  logic                           frame_done;

  modport master (
    output frame_start, req_valid, req_peak_ch, req_pix, rd_addr,
    input  req_ready, res_valid, res_addr, rd_thminus, rd_thpositive,
           rd_delta, rd_written, frame_done
  );

  modport slave (
    input  frame_start, req_valid, req_peak_ch, req_pix, rd_addr,
    output req_ready, res_valid, res_addr, rd_thminus, rd_thpositive,
           rd_delta, rd_written, frame_done
  );

endinterface

// File: rtl/sifh_window_calc.sv
// Combinational window-threshold arithmetic: peak bin index -> THminus,
// THpositive and delta. Shared with single-lane designs.
//   peak       : peak bin index (NB bits)
//   thMinus    : lower window threshold (NP bits)
//   thPositive : upper window threshold (NP bits)
//   delta      : window delta word (NP bits)
module sifh_window_calc
  import sifh_pkg::*;
#(
  parameter int NB = NB_DEFAULT,
  parameter int NP = NP_DEFAULT
) (
  input  logic [NB-1:0] peak,
  output logic [NP-1:0] thMinus,
  output logic [NP-1:0] thPositive,
  output logic [NP-1:0] delta
);

  localparam logic [NP-1:0] SB_W     = NP'(sifh_sb(NB));
  localparam logic [NP-1:0] TWO_SB_W = NP'(2 * sifh_sb(NB));
  localparam logic [NP-1:0] MAX_W    = '1;
  localparam logic [NP-1:0] HI_LIMIT = MAX_W - SB_W;
  localparam logic [NP-1:0] SAT_HI   = MAX_W - NP'((2 ** NB) - 1);

  // Window centred on the peak, clamped so that it never wraps at either end.
  function automatic logic [2*NP-1:0] windowBounds(input logic [NP-1:0] ch);
    logic [NP-1:0] lo;
    logic [NP-1:0] hi;
    if (ch >= HI_LIMIT) begin
      hi = SAT_HI;
      lo = SAT_HI - TWO_SB_W;
    end else if (ch <= SB_W) begin
      lo = '0;
      hi = TWO_SB_W;
    end else begin
      lo = ch - SB_W;
      hi = ch + SB_W;
    end
    return {lo, hi};
  endfunction

  // Sum carried at NP+1 bits, then shifted and wrapped back to NP bits.
  function automatic logic [NP-1:0] windowDelta(input logic [NP-1:0] lo,
                                                 input logic [NP-1:0] hi);
    logic [NP:0] sum;
    sum = {1'b0, lo} + {1'b0, hi} - {{(NB + 1){1'b0}}, hi[NP-1:NB]};
    return NP'(sum << NB);
  endfunction

  logic [NP-1:0] chWord;
  logic [NP-1:0] lo;
  logic [NP-1:0] hi;

  always_comb begin
    chWord     = {peak, {(NP - NB){1'b0}}};
    {lo, hi}   = windowBounds(chWord);
    thMinus    = lo;
    thPositive = hi;
    delta      = windowDelta(lo, hi);
  end

endmodule

// File: rtl/sifh_threshold_scheduler.sv
// Shares one window-threshold calculator among N_REQ histogram-RAM lanes.
// A round-robin arbiter grants one lane per cycle; a two-stage pipeline turns
// the granted peak into THminus/THpositive/delta and writes them into a
// per-pixel result table with a written bitmap and a frame-done flag.
//   clk : clock, rising edge
//   res : asynchronous active-high reset
//   bus : sifh_threshold_scheduler_if slave (requests, results, table read)
module sifh_threshold_scheduler
  import sifh_pkg::*;
#(
  parameter int NB          = NB_DEFAULT,
  parameter int NP          = NP_DEFAULT,
  parameter int N_REQ       = 4,
  parameter int PIX_PER_REQ = 16
) (
  input  logic                          clk,
  input  logic                          res,
  sifh_threshold_scheduler_if.slave     bus
);

  localparam int LW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW    = $clog2(PIX_PER_REQ);
  localparam int AW    = sifh_table_aw(N_REQ, PIX_PER_REQ);
  localparam int TOTAL = N_REQ * PIX_PER_REQ;
  localparam int CW    = AW + 1;

  schedState_e state;
  schedState_e stateNext;

  logic [LW-1:0]    rrPtr;
  logic [N_REQ-1:0] grant;
  logic [LW-1:0]    grantIdx;
  logic             grantAny;

  logic             vld_p1;
  logic [LW-1:0]    lane_p1;
  logic [PW-1:0]    pix_p1;
  logic [NB-1:0]    peak_p1;

  logic [NP-1:0]    calcThMinus;
  logic [NP-1:0]    calcThPositive;
  logic [NP-1:0]    calcDelta;

  logic             vld_p2;
  logic [AW-1:0]    addr_p2;
  logic [NP-1:0]    thMinus_p2;
  logic [NP-1:0]    thPositive_p2;
  logic [NP-1:0]    delta_p2;

  logic [NP-1:0]    thMinusTab    [TOTAL];
  logic [NP-1:0]    thPositiveTab [TOTAL];
  logic [NP-1:0]    deltaTab      [TOTAL];
  logic [TOTAL-1:0] wrMap;
  logic [CW-1:0]    wrCount;
  logic             frameDone;

  logic [NP-1:0]    rdThMinus;
  logic [NP-1:0]    rdThPositive;
  logic [NP-1:0]    rdDelta;
  logic             rdWritten;

  logic             wrEn;
  logic             newEntry;
  logic             lastWrite;

  // A frame_start in the write cycle flushes the in-flight result too.
  assign wrEn      = vld_p2 & ~bus.frame_start;
  assign newEntry  = wrEn & ~wrMap[addr_p2];
  assign lastWrite = newEntry & (wrCount == CW'(TOTAL - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (bus.frame_start)                  stateNext = RUN;
    else if (state == RUN && lastWrite)   stateNext = IDLE;
  end

  // Round-robin search starting at rrPtr; frame_start suppresses any grant.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grantIdx = '0;
    grantAny = 1'b0;
    if (state == RUN && !bus.frame_start) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rrPtr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grantAny && bus.req_valid[LW'(idx)]) begin
          grantAny = 1'b1;
          grantIdx = LW'(idx);
        end
      end
    end
    if (grantAny) grant[grantIdx] = 1'b1;
  end

  assign bus.req_ready = grant;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rrPtr <= '0;
    end else if (grantAny) begin
      rrPtr <= (grantIdx == LW'(N_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

  // ---- stage 1: capture granted lane, pixel and peak ----
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      vld_p1  <= 1'b0;
      lane_p1 <= '0;
      pix_p1  <= '0;
      peak_p1 <= '0;
    end else begin
      vld_p1 <= grantAny;
      if (grantAny) begin
        lane_p1 <= grantIdx;
        pix_p1  <= bus.req_pix[grantIdx];
        peak_p1 <= bus.req_peak_ch[grantIdx];
      end
    end
  end

  sifh_window_calc #(
    .NB (NB),
    .NP (NP)
  ) u_calc (
    .peak       (peak_p1),
    .thMinus    (calcThMinus),
    .thPositive (calcThPositive),
    .delta      (calcDelta)
  );

  // ---- stage 2: register computed window, then write to the table ----
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      vld_p2        <= 1'b0;
      addr_p2       <= '0;
      thMinus_p2    <= '0;
      thPositive_p2 <= '0;
      delta_p2      <= '0;
    end else begin
      vld_p2 <= vld_p1 & ~bus.frame_start;
      if (vld_p1) begin
        addr_p2       <= {lane_p1, pix_p1};
        thMinus_p2    <= calcThMinus;
        thPositive_p2 <= calcThPositive;
        delta_p2      <= calcDelta;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < TOTAL; i++) begin
        thMinusTab[i]    <= '0;
        thPositiveTab[i] <= '0;
        deltaTab[i]      <= '0;
      end
    end else if (wrEn) begin
      thMinusTab[addr_p2]    <= thMinus_p2;
      thPositiveTab[addr_p2] <= thPositive_p2;
      deltaTab[addr_p2]      <= delta_p2;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wrMap     <= '0;
      wrCount   <= '0;
      frameDone <= 1'b0;
    end else if (bus.frame_start) begin
      wrMap     <= '0;
      wrCount   <= '0;
      frameDone <= 1'b0;
    end else begin
      if (wrEn)      wrMap[addr_p2] <= 1'b1;
      if (newEntry)  wrCount        <= wrCount + 1'b1;
      if (lastWrite) frameDone      <= 1'b1;
    end
  end

  // Registered read; a same-cycle write to the entry is seen one cycle later.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rdThMinus    <= '0;
      rdThPositive <= '0;
      rdDelta      <= '0;
      rdWritten    <= 1'b0;
    end else begin
      rdThMinus    <= thMinusTab[bus.rd_addr];
      rdThPositive <= thPositiveTab[bus.rd_addr];
      rdDelta      <= deltaTab[bus.rd_addr];
      rdWritten    <= wrMap[bus.rd_addr];
    end
  end

  assign bus.res_valid     = wrEn;
  assign bus.res_addr      = addr_p2;
  assign bus.rd_thminus    = rdThMinus;
  assign bus.rd_thpositive = rdThPositive;
  assign bus.rd_delta      = rdDelta;
  assign bus.rd_written    = rdWritten;
  assign bus.frame_done    = frameDone;

endmodule

// File: tb/tb_sifh_threshold_scheduler.sv
module tb_sifh_threshold_scheduler;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  sifh_threshold_scheduler_if bus ();

  sifh_threshold_scheduler dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a single-lane request until granted (bounded), then drop it.
  // Returns one cycle after the handshake cycle.
  task automatic issue(input int lane, input logic [7:0] peak, input logic [3:0] pix);
    bus.req_valid[2'(lane)]   = 1'b1;
    bus.req_peak_ch[2'(lane)] = peak;
    bus.req_pix[2'(lane)]     = pix;
    #1;
    for (int n = 0; n < 16 && bus.req_ready[2'(lane)] !== 1'b1; n++) step();
    chk($sformatf("grant_lane%0d", lane), 32'(bus.req_ready[2'(lane)]), 32'd1);
    step();
    bus.req_valid[2'(lane)] = 1'b0;
  endtask

  task automatic readChk(input string tag, input int addr, input int thm,
                         input int thp, input int dl, input int wr);
    bus.rd_addr = 6'(addr);
    step();
    chk({tag, "_thm"},     32'(bus.rd_thminus),    32'(thm));
    chk({tag, "_thp"},     32'(bus.rd_thpositive), 32'(thp));
    chk({tag, "_delta"},   32'(bus.rd_delta),      32'(dl));
    chk({tag, "_written"}, 32'(bus.rd_written),    32'(wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [3:0] expRdy [5];
  int         expAddr [5];
  logic [3:0] g;

  initial begin
    expRdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    expAddr = '{1, 18, 35, 52, 1};

    res             = 1'b1;
    bus.frame_start = 1'b0;
    bus.req_valid   = '0;
    bus.req_peak_ch = '0;
    bus.req_pix     = '0;
    bus.rd_addr     = '0;
    repeat (2) step();

    chk("rst_ready",      32'(bus.req_ready),  32'd0);
    chk("rst_res_valid",  32'(bus.res_valid),  32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_rd_thm",     32'(bus.rd_thminus), 32'd0);
    chk("rst_rd_written", 32'(bus.rd_written), 32'd0);
    res = 1'b0;
    step();

    // IDLE ignores requests; frame_start cycle grants nothing
    bus.req_valid[0]   = 1'b1;
    bus.req_peak_ch[0] = 8'd100;
    bus.req_pix[0]     = 4'd0;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd0);
    bus.frame_start = 1'b1;
    #1;
    chk("fs_cycle_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.frame_start = 1'b0;
    #1;
    chk("t0_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid[0] = 1'b0;
    #1;
    chk("t1_res_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk("t2_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t2_res_addr",  32'(bus.res_addr),  32'd0);
    bus.rd_addr = 6'd0;
    step();
    chk("rdw_old_thm",     32'(bus.rd_thminus), 32'd0);
    chk("rdw_old_written", 32'(bus.rd_written), 32'd0);
    step();
    chk("p100_thm",     32'(bus.rd_thminus),    32'd25408);
    chk("p100_thp",     32'(bus.rd_thpositive), 32'd25792);
    chk("p100_delta",   32'(bus.rd_delta),      32'd39936);
    chk("p100_written", 32'(bus.rd_written),    32'd1);

    // Boundary peaks, back-to-back on lane 1
    issue(1, 8'd0,   4'd2);
    issue(1, 8'd1,   4'd3);
    issue(1, 8'd255, 4'd4);
    repeat (3) step();
    readChk("p0",   18, 0,     384,   32512, 1);
    readChk("p1",   19, 64,    448,   65280, 1);
    readChk("p255", 20, 65088, 65472, 256,   1);

    // frame_start one cycle after a handshake flushes the result
    issue(2, 8'd50, 4'd7);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    #1;
    chk("flush_res_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk("flush_frame_done", 32'(bus.frame_done), 32'd0);
    readChk("flushed", 39, 0, 0, 0, 0);
    readChk("kept0", 0, 25408, 25792, 39936, 0);

    // Reset asserted mid-burst between clock edges
    for (int l = 0; l < 4; l++) begin
      bus.req_pix[2'(l)]     = 4'(l + 1);
      bus.req_peak_ch[2'(l)] = 8'd10;
    end
    bus.req_valid = 4'hF;
    repeat (3) step();
    #2;
    chk("pre_rst_res_valid", 32'(bus.res_valid),  32'd1);
    chk("pre_rst_rd_thm",    32'(bus.rd_thminus), 32'd25408);
    res = 1'b1;
    #1;
    chk("arst_ready",     32'(bus.req_ready),     32'd0);
    chk("arst_res_valid", 32'(bus.res_valid),     32'd0);
    chk("arst_res_addr",  32'(bus.res_addr),      32'd0);
    chk("arst_rd_thm",    32'(bus.rd_thminus),    32'd0);
    chk("arst_rd_thp",    32'(bus.rd_thpositive), 32'd0);
    chk("arst_rd_delta",  32'(bus.rd_delta),      32'd0);
    step();
    step();
    res = 1'b0;
    step();
    chk("post_rst_idle_ready", 32'(bus.req_ready),  32'd0);
    chk("post_rst_table_clr",  32'(bus.rd_thminus), 32'd0);
    bus.frame_start = 1'b1;
    #1;
    chk("fs_wins_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.frame_start = 1'b0;

    // Rotation from lane 0 with all lanes requesting
    for (int k = 0; k < 7; k++) begin
      if (k == 5) bus.req_valid = '0;
      #1;
      if (k < 5) chk($sformatf("rr_grant%0d", k), 32'(bus.req_ready), 32'(expRdy[k]));
      if (k >= 2) begin
        chk($sformatf("rr_res_valid%0d", k), 32'(bus.res_valid), 32'd1);
        chk($sformatf("rr_res_addr%0d", k),  32'(bus.res_addr),  32'(expAddr[k-2]));
      end
      step();
    end
    step();

    // Fill all 64 entries; entry 5 written three times in total
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    issue(0, 8'd1, 4'd5);
    issue(0, 8'd0, 4'd5);
    repeat (3) step();
    readChk("rewrite1", 5, 0, 384, 32512, 1);
    chk("early_frame_done", 32'(bus.frame_done), 32'd0);

    for (int p = 0; p < 16; p++) begin
      for (int l = 0; l < 4; l++) begin
        bus.req_pix[2'(l)]     = 4'(p);
        bus.req_peak_ch[2'(l)] = 8'd100;
      end
      bus.req_valid = 4'hF;
      #1;
      for (int c = 0; c < 4; c++) begin
        g = bus.req_ready;
        step();
        bus.req_valid = bus.req_valid & ~g;
        #1;
      end
      if (p == 7) chk("half_frame_done", 32'(bus.frame_done), 32'd0);
    end
    chk("last_t1_frame_done", 32'(bus.frame_done), 32'd0);
    step();
    chk("last_t2_frame_done", 32'(bus.frame_done), 32'd0);
    chk("last_t2_res_valid",  32'(bus.res_valid),  32'd1);
    step();
    chk("last_t3_frame_done", 32'(bus.frame_done), 32'd1);

    // Pending request while IDLE waits for the next frame
    bus.req_valid[2]   = 1'b1;
    bus.req_pix[2]     = 4'd9;
    bus.req_peak_ch[2] = 8'd20;
    #1;
    chk("done_idle_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("done_hold", 32'(bus.frame_done), 32'd1);
    readChk("rewrite_last", 5, 25408, 25792, 39936, 1);
    chk("done_hold2", 32'(bus.frame_done), 32'd1);
    bus.frame_start = 1'b1;
    #1;
    chk("pending_fs_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.frame_start = 1'b0;
    #1;
    chk("new_frame_done_clr", 32'(bus.frame_done), 32'd0);
    chk("pending_served",     32'(bus.req_ready),  32'd4);
    step();
    bus.req_valid = '0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
